instr_fetch: RTL and testbench

- Fetch-side initiator for the combinational instruction memory (word-addressed internally, byte address in, 32-bit instruction out, zero-latency read).
- Owns the PC and presents it as the memory address every cycle.
- Captures the returned instruction with its PC into a small prefetch queue.
- Hands entries to decode over a valid/ready handshake; supports stall (via ready), halt (fetch_en) and branch/jump redirect with flush.

---
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch initiator: owns the PC, drives a zero-latency instruction memory
// and buffers {pc, instr} pairs in a DEPTH-entry queue for decode. Optional perf counters: IFETCH_PERF_EN.
module instr_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  DEPTH_C = DEPTH[PTR_W:0];

    logic [31:0]      pc_q;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop, push, full;

    assign imem_addr = pc_q;
    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = fetch_en & ~redirect_valid & (~full | pop);

    // Head is masked while empty so flushed entries never leak onto out_*.
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc_q   <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= pc_q;
                instr_mem[wr_ptr] <= imem_instr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
                pc_q              <= pc_q + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (fetch_en & ~redirect_valid & full & ~pop)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized + directed bench for instr_fetch: a queue-level reference model feeds
// a scoreboard that an independent monitor drains on every decode handshake.
module tb_instr_fetch;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_instr;
    logic        fetch_en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_pc, out_instr;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Boot image words 1 and 2 fixed; everything else is a deterministic scramble of the word index.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2];
        if (w == 30'd1) return 32'h0ff1_0113;
        if (w == 30'd2) return 32'h0020_0313;
        return {w[15:0], ~w[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    // Reference model state
    logic [63:0] exp_q[$];
    int          mcount;
    logic [31:0] mpc;
    logic [31:0] m_pf, m_ps;
    // Snapshot of what the DUT should present during the current cycle
    logic        exp_valid;
    logic [31:0] exp_addr, exp_pf, exp_ps;
    logic        do_flush = 1'b0;
    logic        armed = 1'b0;
    int          pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus; model is advanced to the state after the coming edge.
    task automatic step(input logic rst, input logic en, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        logic pop_m, push_m;
        @(negedge clk);
        #1;
        rst_n = ~rst; fetch_en = en; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        exp_valid = (mcount != 0);
        exp_addr  = mpc;
        exp_pf    = m_pf;
        exp_ps    = m_ps;
        if (rst) begin
            mcount = 0; mpc = RESET_PC; m_pf = '0; m_ps = '0; do_flush = 1'b1;
        end else if (rv) begin
            mcount = 0; mpc = {rpc[31:2], 2'b00}; do_flush = 1'b1;
        end else begin
            pop_m  = (mcount > 0) && rdy;
            push_m = en && ((mcount < DEPTH) || pop_m);
            if (en && mcount == DEPTH && !pop_m) m_ps = m_ps + 1;
            if (push_m) begin
                exp_q.push_back({mpc, mem_word(mpc)});
                mpc  = mpc + 32'd4;
                m_pf = m_pf + 1;
            end
            mcount = mcount + int'(push_m) - int'(pop_m);
        end
    endtask

    // Monitor: samples mid-cycle, after inputs settle and before the next edge.
    always begin
        logic [63:0] e;
        @(negedge clk);
        #3;
        if (armed) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            chk("imem_addr", {32'd0, imem_addr}, {32'd0, exp_addr});
`ifdef IFETCH_PERF_EN
            chk("perf_fetch", {32'd0, perf_fetch_cnt}, {32'd0, exp_pf});
            chk("perf_stall", {32'd0, perf_stall_cnt}, {32'd0, exp_ps});
`endif
            if (!out_valid)
                chk("idle_out", {out_pc, out_instr}, 64'd0);
            if (out_valid && out_ready && rst_n) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL beat: got unexpected pc=%h instr=%h, required none", out_pc, out_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_pc", {32'd0, out_pc}, {32'd0, e[63:32]});
                    chk("beat_instr", {32'd0, out_instr}, {32'd0, e[31:0]});
                end
            end
            if (do_flush) begin
                exp_q.delete();
                do_flush = 1'b0;
            end
        end
    end

    initial begin
        mcount = 0; mpc = RESET_PC; m_pf = '0; m_ps = '0;
        step(1, 0, 0, 0, 0);
        armed = 1'b1;

        // free run from reset
        repeat (6) step(0, 1, 0, 0, 1);
        // stall from reset, then release
        step(1, 0, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0, 1);
        // redirect while full, decode not ready
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0043, 0);
        repeat (3) step(0, 1, 0, 0, 1);
        // redirect with a simultaneous pop while full
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0100, 1);
        repeat (3) step(0, 1, 0, 0, 1);
        // PC wrap at top of address space
        step(0, 1, 1, 32'hFFFF_FFFE, 1);
        repeat (4) step(0, 1, 0, 0, 1);
        // fetch_en low: queue drains, PC holds
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        // reset mid-stream with two entries queued
        repeat (2) step(0, 1, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0080, 0);
        repeat (3) step(0, 1, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, en, rv, rdy;
            r   = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) < 8);
            rv  = ($urandom_range(0, 14) == 0);
            rdy = r ? 1'b0 : ($urandom_range(0, 9) < 6);
            step(r, en, rv, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom, rdy);
        end

        // drain and confirm nothing is left outstanding
        repeat (4) step(0, 0, 0, 0, 1);
        @(negedge clk);
        #4;
        chk("drained", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
